// File: rtl/req_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface req_grant_arbiter_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned WIDTH_W = $clog2(WIDTH)
) ();
    logic [WIDTH-1:0]   req;
    logic [WIDTH-1:0]   gnt;
    logic               gnt_valid;
    logic [WIDTH_W-1:0] gnt_bin;
    logic               err_timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_bin,
        input  err_timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_bin,
        output err_timeout
    );
endinterface

// File: rtl/req_grant_arbiter.sv
// Round-robin request/hold/release arbiter with registered one-hot grant.
// Optional grant length limit enabled by defining ARB_HOLD_LIMIT_EN.
module req_grant_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WIDTH_W  = $clog2(WIDTH),
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               nrst,
    req_grant_arbiter_if.slave bus
);
    if (WIDTH < 2) begin : g_width_check
        $error("req_grant_arbiter: WIDTH must be >= 2");
    end
    if (HOLD_MAX < 1) begin : g_hold_check
        $error("req_grant_arbiter: HOLD_MAX must be >= 1");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [WIDTH_W-1:0] gnt_bin_q, gnt_bin_d;
    logic [WIDTH_W-1:0] ptr_q, ptr_d;
    logic [WIDTH_W-1:0] pick;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned CntWidth = $clog2(HOLD_MAX + 1);
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Lowest set bit above the pointer wins; otherwise lowest set bit of the full request.
    always_comb begin
        pick = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (bus.req[i]) pick = WIDTH_W'(i);
        end
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (bus.req[i] && (i > int'(ptr_q))) pick = WIDTH_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_bin_d   = gnt_bin_q;
        ptr_d       = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gnt_valid_d = 1'b1;
                    gnt_bin_d   = pick;
                    ptr_d       = pick;
                    state_d     = StGrant;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StGrant: begin
                if (!bus.req[gnt_bin_q]) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_bin_d   = '0;
                    state_d     = StIdle;
                end
`ifdef ARB_HOLD_LIMIT_EN
                // Forced revoke leaves the pointer on the revoked owner so others go first.
                else if (cnt_q == CntWidth'(HOLD_MAX - 1)) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_bin_d   = '0;
                    state_d     = StIdle;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_bin_q   <= '0;
            ptr_q       <= WIDTH_W'(WIDTH - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_bin_q   <= gnt_bin_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_bin   = gnt_bin_q;
endmodule

// File: tb/tb_req_grant_arbiter.sv
// Randomized and directed bench for req_grant_arbiter against a round-robin reference model.
// Define ARB_HOLD_LIMIT_EN for both RTL and bench to exercise the grant length limit.
module tb_req_grant_arbiter;
    localparam int W    = 4;
    localparam int HOLD = 8;

    logic clk;
    logic nrst;

    int vectors;
    int miscompares;

    // Reference model: current owner (-1 = none), last owner, cycles held, timeout pulse.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_err;

    req_grant_arbiter_if #(.WIDTH(W)) bus ();

    req_grant_arbiter #(
        .WIDTH    (W),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] b;
        g = '0;
        b = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            b = 2'(m_owner);
        end
        return {g, (m_owner >= 0), b, m_err};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {bus.gnt, bus.gnt_valid, bus.gnt_bin, bus.err_timeout};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = W - 1;
        m_hold  = 0;
        m_err   = 1'b0;
    endtask

    // One clock of the round-robin rules, applied with the request seen at the edge.
    task automatic model_update(input logic [3:0] r);
        m_err = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (m_hold == HOLD - 1) begin
                m_owner = -1;
                m_err   = 1'b1;
            end
`endif
            else begin
                m_hold++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= W; k++) begin
                int idx;
                idx = (m_ptr + k) % W;
                if (r[idx]) begin
                    m_owner = idx;
                    m_ptr   = idx;
                    m_hold  = 0;
                    break;
                end
            end
        end
    endtask

    // Drive at negedge, clock once, advance the model, return at next negedge for sampling.
    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        model_update(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst    = 1'b0;
        bus.req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        @(negedge clk);
        nrst    = 1'b0;
        bus.req = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = obs_vec();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, 8'h00);
            end
        end
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'b0000);
            obs = obs_vec();
            vectors++;
            if (obs !== 8'h00 || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_hold_release();
        logic [7:0] obs;
        do_reset();
        step(4'b0101);
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.gnt_bin !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant got=%b/%0d want=0001/0", bus.gnt, bus.gnt_bin);
        end
        for (int i = 0; i < 10; i++) begin
            step(4'b0101);
            obs = obs_vec();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0100);
            obs = obs_vec();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL release cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.gnt_bin !== 2'd2) begin
            miscompares++;
            $display("FAIL regrant got=%b/%0d want=0100/2", bus.gnt, bus.gnt_bin);
        end
    endtask

    task automatic test_rotation();
        int         exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int         seen[$];
        int         held;
        bit         prev_valid;
        logic [3:0] r;
        logic [7:0] obs;
        do_reset();
        held       = 0;
        prev_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && seen.size() < 6; cyc++) begin
            r = 4'b1111;
            if (m_owner >= 0 && held == 3) r[m_owner] = 1'b0;
            step(r);
            held = (m_owner >= 0) ? held + 1 : 0;
            obs = obs_vec();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL rotation cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
            if (bus.gnt_valid === 1'b1 && !prev_valid) seen.push_back(int'(bus.gnt_bin));
            prev_valid = (bus.gnt_valid === 1'b1);
        end
        vectors++;
        if (seen.size() != 6) begin
            miscompares++;
            $display("FAIL rotation_count got=%0d want=6", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 6; i++) begin
            vectors++;
            if (seen[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL rotation_order idx=%0d got=%0d want=%0d", i, seen[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(4'b1001);
        vectors++;
        if (bus.gnt !== 4'b0001 || exp_vec() !== obs_vec()) begin
            miscompares++;
            $display("FAIL wrap_low got=%b want=0001", bus.gnt);
        end
        step(4'b1000);
        vectors++;
        if (bus.gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL wrap_idle got=%b want=0000", bus.gnt);
        end
        step(4'b1001);
        vectors++;
        if (bus.gnt !== 4'b1000 || bus.gnt_bin !== 2'd3 || exp_vec() !== obs_vec()) begin
            miscompares++;
            $display("FAIL wrap_high got=%b/%0d want=1000/3", bus.gnt, bus.gnt_bin);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] obs;
        do_reset();
        step(4'b0100);
        vectors++;
        if (bus.gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL async_setup got=%b want=0100", bus.gnt);
        end
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        obs = obs_vec();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL async_clear got=%b want=%b", obs, 8'h00);
        end
        bus.req = 4'b1111;
        @(negedge clk);
        nrst = 1'b1;
        step(4'b1111);
        vectors++;
        if (bus.gnt !== 4'b0001 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_first got=%b want=0001", bus.gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [7:0] obs;
        do_reset();
        r = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            step(r);
            obs = obs_vec();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d req=%b got=%b want=%b", cyc, r, obs, exp_vec());
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [7:0] obs;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            step(4'b0011);
            obs = obs_vec();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold_limit cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
`ifdef ARB_HOLD_LIMIT_EN
            if (cyc == HOLD) begin
                vectors++;
                if (bus.gnt !== 4'b0000 || bus.err_timeout !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_pulse got=%b/%b want=0000/1", bus.gnt,
                             bus.err_timeout);
                end
            end
            if (cyc == HOLD + 1) begin
                vectors++;
                if (bus.gnt !== 4'b0010 || bus.err_timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL timeout_next got=%b/%b want=0010/0", bus.gnt,
                             bus.err_timeout);
                end
            end
`else
            vectors++;
            if (bus.gnt !== 4'b0001 || bus.err_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL unbounded cyc=%0d got=%b/%b want=0001/0", cyc, bus.gnt,
                         bus.err_timeout);
            end
`endif
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst        = 1'b1;
        bus.req     = '0;
        model_reset();
        test_reset();
        test_hold_release();
        test_rotation();
        test_wrap();
        test_async_reset();
        test_hold_limit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
